// File: rtl/alu_pkg.sv
// Shared ALU definitions: data/opcode widths, the opcode set and the result
// record that travels from the ALU into the result FIFO.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_NOT  = 4'h5,
    OP_SHL  = 4'h6,
    OP_SHR  = 4'h7,
    OP_INC  = 4'h8,
    OP_DEC  = 4'h9,
    OP_PASA = 4'hA,
    OP_PASB = 4'hB
  } alu_op_e;

  typedef struct packed {
    logic [DATA_W-1:0] y;
    logic              co;
    logic              zero;
    logic [OP_W-1:0]   op;
  } alu_result_t;

  // The zero flag is captured alongside the result so the consumer never recomputes it.
  function automatic alu_result_t make_result(input logic [DATA_W-1:0] y,
                                              input logic              co,
                                              input logic [OP_W-1:0]   op);
    alu_result_t r;
    r.y    = y;
    r.co   = co;
    r.zero = (y == '0);
    r.op   = op;
    return r;
  endfunction

endpackage

// File: rtl/alu_result_fifo_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/alu_result_fifo.sv
// Circular FIFO capturing ALU results for a valid/ready consumer. The ALU
// cannot stall, so results arriving while full are dropped and counted.
module alu_result_fifo #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 4,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_y,
  input  logic                     in_co,
  input  logic [OP_W-1:0]          in_op,
  input  logic                     clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_y,
  output logic                     out_co,
  output logic                     out_zero,
  output logic [OP_W-1:0]          out_op,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [CNT_W-1:0]         drop_cnt
);

  import alu_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  alu_result_t       r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  alu_result_t       w_wr_entry;
  alu_result_t       w_head;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_pop      = !w_empty && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push     = in_valid && (!w_full || w_pop);
  assign w_drop     = in_valid && w_full && !w_pop && !clr;
  assign w_wr_entry = make_result(in_y, in_co, in_op);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is left unreset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push && !clr) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_drop),
    .clr   (clr),
    .count (drop_cnt)
  );

  assign w_head    = w_empty ? '0 : r_mem[r_rd_ptr];
  assign out_valid = !w_empty;
  assign out_y     = w_head.y;
  assign out_co    = w_head.co;
  assign out_zero  = w_head.zero;
  assign out_op    = w_head.op;
  assign count     = r_count;
  assign full      = w_full;
  assign empty     = w_empty;

  a_count_bound: assert property (@(posedge clk) disable iff (!reset)
    r_count <= CW'(DEPTH));

  a_flags_exclusive: assert property (@(posedge clk) disable iff (!reset)
    !(w_full && w_empty));

  a_head_stable: assert property (@(posedge clk) disable iff (!reset)
    (out_valid && !out_ready && !clr) |=>
      (out_valid && $stable({out_y, out_co, out_zero, out_op})));

endmodule

// File: tb/tb_alu_result_fifo.sv
// Randomized and directed bench for alu_result_fifo against a queue-based
// reference model of the FIFO and its saturating drop counter.
module tb_alu_result_fifo;

  localparam int DEPTH   = 4;
  localparam int CNT_W   = 8;
  localparam int DROPMAX = (1 << CNT_W) - 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_y;
  logic       in_co;
  logic [3:0] in_op;
  logic       clr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_y;
  logic       out_co;
  logic       out_zero;
  logic [3:0] out_op;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic [7:0] drop_cnt;

  int vectors    = 0;
  int miscompares = 0;

  logic [12:0] mq[$];
  int          mDrops = 0;

  alu_result_fifo #(.DATA_W(8), .OP_W(4), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_y      (in_y),
    .in_co     (in_co),
    .in_op     (in_op),
    .clr       (clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_co    (out_co),
    .out_zero  (out_zero),
    .out_op    (out_op),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  wire [27:0] dutVec = {out_valid, out_y, out_co, out_zero, out_op,
                        count, full, empty, drop_cnt};

  // Reference model advances by one clock edge using the current inputs.
  task automatic cycle();
    bit pop;
    bit push;
    if (clr) begin
      mq.delete();
      mDrops = 0;
    end else begin
      pop  = (mq.size() > 0) && out_ready;
      push = in_valid && ((mq.size() < DEPTH) || pop);
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back({in_y, in_co, in_op});
      else if (in_valid && mDrops < DROPMAX) mDrops++;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [27:0] expVec();
    logic [12:0] h;
    logic        v;
    v = (mq.size() > 0);
    h = v ? mq[0] : 13'd0;
    return {v, h[12:5], h[4], (v && h[12:5] == 8'h00), h[3:0],
            3'(mq.size()), (mq.size() == DEPTH), (mq.size() == 0), 8'(mDrops)};
  endfunction

  task automatic idleInputs();
    in_valid  = 1'b0;
    in_y      = 8'h00;
    in_co     = 1'b0;
    in_op     = 4'h0;
    clr       = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idleInputs();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (dutVec !== 28'h0000_0100) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %h expected %h", dutVec, 28'h0000_0100);
    end
    reset = 1'b1;
    cycle();
    vectors++;
    if (count !== 3'd0 || empty !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_idle: count=%0d empty=%b valid=%b expected 0/1/0", count, empty, out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_y = 8'h60 + 8'(i); in_co = 1'b0; in_op = 4'h1;
      cycle();
    end
    idleInputs();
    vectors++;
    if (count !== 3'd2) begin
      miscompares++;
      $display("[TB] FAIL midreset_queued: count=%0d expected 2", count);
    end
    #2 reset = 1'b0;
    mq.delete();
    mDrops = 0;
    #1;
    vectors++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_y !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL midreset_immediate: count=%0d valid=%b y=%h expected 0/0/00", count, out_valid, out_y);
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    cycle();
    vectors++;
    if (dutVec !== expVec()) begin
      miscompares++;
      $display("[TB] FAIL midreset_after: got %h expected %h", dutVec, expVec());
    end
  endtask

  task automatic test_single_push();
    in_valid = 1'b1; in_y = 8'h00; in_co = 1'b1; in_op = 4'h3; out_ready = 1'b1;
    cycle();
    idleInputs();
    vectors++;
    if (count !== 3'd1) begin
      miscompares++;
      $display("[TB] FAIL single_count: got %0d expected 1", count);
    end
    vectors++;
    if (out_valid !== 1'b1 || out_y !== 8'h00 || out_co !== 1'b1 || out_zero !== 1'b1 || out_op !== 4'h3) begin
      miscompares++;
      $display("[TB] FAIL single_head: valid=%b y=%h co=%b zero=%b op=%h expected 1/00/1/1/3",
               out_valid, out_y, out_co, out_zero, out_op);
    end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    vectors++;
    if (empty !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_pop: empty=%b valid=%b expected 1/0", empty, out_valid);
    end
  endtask

  task automatic test_fill_and_drop();
    logic [7:0] data [5];
    data[0] = 8'h11; data[1] = 8'h22; data[2] = 8'h33; data[3] = 8'h44; data[4] = 8'h55;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_y = data[i]; in_co = 1'($urandom); in_op = 4'($urandom);
      cycle();
    end
    vectors++;
    if (full !== 1'b1 || count !== 3'd4) begin
      miscompares++;
      $display("[TB] FAIL fill_full: full=%b count=%0d expected 1/4", full, count);
    end
    in_y = data[4];
    cycle();
    idleInputs();
    vectors++;
    if (drop_cnt !== 8'd1 || count !== 3'd4) begin
      miscompares++;
      $display("[TB] FAIL fill_drop: drop=%0d count=%0d expected 1/4", drop_cnt, count);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (out_y !== data[i] || out_valid !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL fill_order%0d: y=%h valid=%b expected %h/1", i, out_y, out_valid, data[i]);
      end
      out_ready = 1'b1;
      cycle();
    end
    out_ready = 1'b0;
    vectors++;
    if (empty !== 1'b1 || out_y !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL fill_drained: empty=%b y=%h expected 1/00", empty, out_y);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1; in_y = 8'($urandom); in_co = 1'($urandom); in_op = 4'($urandom);
      cycle();
    end
    for (int i = 0; i < 2 * DEPTH; i++) begin
      in_valid = 1'b1; out_ready = 1'b1;
      in_y = (i == 2 * DEPTH - 1) ? 8'hAA : 8'($urandom);
      in_co = 1'($urandom); in_op = 4'($urandom);
      cycle();
      vectors++;
      if (count !== 3'd4 || full !== 1'b1 || drop_cnt !== 8'(mDrops)) begin
        miscompares++;
        $display("[TB] FAIL pushpop_full%0d: count=%0d full=%b drop=%0d expected 4/1/%0d",
                 i, count, full, drop_cnt, mDrops);
      end
    end
    idleInputs();
    for (int i = 0; i < DEPTH; i++) begin
      vectors++;
      if (dutVec !== expVec()) begin
        miscompares++;
        $display("[TB] FAIL pushpop_drain%0d: got %h expected %h", i, dutVec, expVec());
      end
      if (i == DEPTH - 1) begin
        vectors++;
        if (out_y !== 8'hAA) begin
          miscompares++;
          $display("[TB] FAIL pushpop_last: y=%h expected aa", out_y);
        end
      end
      out_ready = 1'b1;
      cycle();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_saturation();
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 300; i++) begin
      in_y = 8'($urandom); in_co = 1'($urandom); in_op = 4'($urandom);
      cycle();
    end
    vectors++;
    if (drop_cnt !== 8'd255 || count !== 3'd4) begin
      miscompares++;
      $display("[TB] FAIL sat_reach: drop=%0d count=%0d expected 255/4", drop_cnt, count);
    end
    repeat (5) cycle();
    vectors++;
    if (drop_cnt !== 8'd255) begin
      miscompares++;
      $display("[TB] FAIL sat_hold: drop=%0d expected 255", drop_cnt);
    end
    clr = 1'b1; in_valid = 1'b1; in_y = 8'h5A;
    cycle();
    idleInputs();
    vectors++;
    if (drop_cnt !== 8'd0 || count !== 3'd0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL clr_effect: drop=%0d count=%0d valid=%b expected 0/0/0", drop_cnt, count, out_valid);
    end
    cycle();
    vectors++;
    if (count !== 3'd0 || empty !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL clr_nostore: count=%0d empty=%b expected 0/1", count, empty);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      in_y      = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
      in_co     = 1'($urandom);
      in_op     = 4'($urandom);
      cycle();
      vectors++;
      if (dutVec !== expVec()) begin
        miscompares++;
        $display("[TB] FAIL random%0d: got %h expected %h", i, dutVec, expVec());
      end
    end
    idleInputs();
  endtask

  initial begin
    test_reset();
    test_reset_midstream();
    test_single_push();
    test_fill_and_drop();
    test_full_push_pop();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
